// File: rtl/seq_sched_pkg.sv
// Shared types and width helpers for seq_detect_scheduler and its round-robin arbiter.
package seq_sched_pkg;

  typedef enum logic {IDLE, SHIFT} ctrl_state_e;

  typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_state_e;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = calc_ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  always_comb begin
    int unsigned c;
    logic [CH_W-1:0] cand;
    c    = 0;
    cand = '0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c    = (32'(ptr) + i) % 32'(NUM_CH);
      cand = CH_W'(c);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One serial "1010" Mealy detector time-shared among NUM_CH word requesters.
// Define SEQ_SCHED_OVERLAP_EN for overlapping detection (D --0--> C instead of A).
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WORD_W = 8,
  localparam int CH_W   = calc_ch_w(NUM_CH),
  localparam int CNT_W  = calc_cnt_w(WORD_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*WORD_W-1:0] data_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic                     busy_o,
  output logic                     bit_o,
  output logic                     hit_o,
  output logic                     res_valid_o,
  output logic [CH_W-1:0]          res_ch_o,
  output logic [CNT_W-1:0]         res_cnt_o
);

  localparam int IDX_W = $clog2(WORD_W);

`ifdef SEQ_SCHED_OVERLAP_EN
  localparam det_state_e DET_D_ZERO = DET_C;
`else
  localparam det_state_e DET_D_ZERO = DET_A;
`endif

  function automatic det_state_e det_next(input det_state_e s, input logic b);
    case (s)
      DET_A:   return b ? DET_B : DET_A;
      DET_B:   return b ? DET_B : DET_C;
      DET_C:   return b ? DET_D : DET_A;
      default: return b ? DET_B : DET_D_ZERO;
    endcase
  endfunction

  ctrl_state_e         state_q, state_d;
  det_state_e          det_q, det_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;

  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [WORD_W-1:0]   gnt_word;
  logic                bit_w;
  logic                hit_w;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    gnt_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) gnt_word = data_i[k*WORD_W +: WORD_W];
    end
  end

  // The word is shifted left, so the MSB of shift_q is always the bit under test.
  assign bit_w = (state_q == SHIFT) && shift_q[WORD_W-1];
  assign hit_w = (state_q == SHIFT) && (det_q == DET_D) && !bit_w;

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_cnt_d   = res_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = SHIFT;
          shift_d = gnt_word;
          ch_d    = gnt_idx;
          cnt_d   = '0;
          det_d   = DET_A;
          idx_d   = IDX_W'(WORD_W - 1);
          ack_d   = gnt;
          ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      SHIFT: begin
        det_d   = det_next(det_q, bit_w);
        cnt_d   = cnt_q + CNT_W'(hit_w);
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d     = IDLE;
          res_valid_d = 1'b1;
          res_ch_d    = ch_q;
          res_cnt_d   = cnt_q + CNT_W'(hit_w);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      det_q       <= DET_A;
      ptr_q       <= '0;
      ch_q        <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign ack_o       = ack_q;
  assign busy_o      = (state_q == SHIFT);
  assign bit_o       = bit_w;
  assign hit_o       = hit_w;
  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_cnt_o   = res_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed, table-driven bench for seq_detect_scheduler (NUM_CH=4, WORD_W=8).
module tb_seq_detect_scheduler;

  localparam int NUM_CH = 4;
  localparam int WORD_W = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH*WORD_W-1:0] data_i;
  logic [NUM_CH-1:0]        ack_o;
  logic                     busy_o;
  logic                     bit_o;
  logic                     hit_o;
  logic                     res_valid_o;
  logic [1:0]               res_ch_o;
  logic [3:0]               res_cnt_o;

  seq_detect_scheduler #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .busy_o      (busy_o),
    .bit_o       (bit_o),
    .hit_o       (hit_o),
    .res_valid_o (res_valid_o),
    .res_ch_o    (res_ch_o),
    .res_cnt_o   (res_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hits: bit j-1 set when hit_o is expected in shift cycle j
  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic [7:0] hits;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [8];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits on negedges until ack_o is seen or the budget runs out; returns cycles waited.
  task automatic wait_ack(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack_o == '0 && waited < 20);
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (res_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, ".res_seen"}, 32'(res_valid_o), 32'd1);
  endtask

  // Called at a negedge; raises the request now so back-to-back calls are gapless.
  task automatic run_vector(input int idx, input vec_t v);
    int         waited;
    logic [7:0] bits;
    logic [7:0] hits;
    string      tag;
    tag = $sformatf("v%0d", idx);
    data_i[v.ch*WORD_W +: WORD_W] = v.data;
    req_i[v.ch] = 1'b1;
    wait_ack(waited);
    check({tag, ".ack_lat"}, 32'(waited), 32'd1);
    check({tag, ".ack"}, 32'(ack_o), 32'(4'b0001 << v.ch));
    req_i[v.ch] = 1'b0;
    bits = '0;
    hits = '0;
    bits[WORD_W-1] = bit_o;
    hits[0]        = hit_o;
    for (int j = 2; j <= WORD_W; j++) begin
      @(negedge clk);
      bits[WORD_W-j] = bit_o;
      hits[j-1]      = hit_o;
    end
    @(negedge clk);
    check({tag, ".bits"}, 32'(bits), 32'(v.data));
    check({tag, ".hits"}, 32'(hits), 32'(v.hits));
    check({tag, ".res_valid"}, 32'(res_valid_o), 32'd1);
    check({tag, ".busy_end"}, 32'(busy_o), 32'd0);
    check({tag, ".res_ch"}, 32'(res_ch_o), 32'(v.ch));
    check({tag, ".res_cnt"}, 32'(res_cnt_o), 32'(v.cnt));
  endtask

  initial begin
    int waited;
    int cnt;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    req_i  = '0;
    data_i = '0;

    tbl[0] = '{2'd2, 8'h5A, 8'h80, 4'd1};
`ifdef SEQ_SCHED_OVERLAP_EN
    tbl[1] = '{2'd0, 8'hAA, 8'hA8, 4'd3};
`else
    tbl[1] = '{2'd0, 8'hAA, 8'h88, 4'd2};
`endif
    tbl[2] = '{2'd1, 8'h0A, 8'h80, 4'd1};
    tbl[3] = '{2'd1, 8'h0A, 8'h80, 4'd1};
    tbl[4] = '{2'd3, 8'hA0, 8'h08, 4'd1};
    tbl[5] = '{2'd3, 8'h05, 8'h00, 4'd0};
    tbl[6] = '{2'd0, 8'hFF, 8'h00, 4'd0};
    tbl[7] = '{2'd2, 8'h33, 8'h00, 4'd0};

    #1;
    check("reset_outputs",
          32'({ack_o, busy_o, bit_o, hit_o, res_valid_o, res_ch_o, res_cnt_o}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Round robin from pointer 0 with every request held high
    req_i = '1;
    wait_ack(waited);
    check("rr0.lat", 32'(waited), 32'd1);
    check("rr0.ack", 32'(ack_o), 32'(4'b0001));
    for (int k = 1; k <= 4; k++) begin
      wait_ack(waited);
      check($sformatf("rr%0d.spacing", k), 32'(waited), 32'(WORD_W + 1));
      check($sformatf("rr%0d.ack", k), 32'(ack_o), 32'(4'b0001 << (k % 4)));
    end
    req_i = '0;
    wait_res("rr_tail");
    check("rr_tail.res_ch", 32'(res_ch_o), 32'd0);

    for (int i = 0; i < 8; i++) run_vector(i, tbl[i]);

    // Idle: nothing moves, and the pointer (now 3 after the ch2 grant) is kept
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || ack_o !== '0 || hit_o !== 1'b0) cnt++;
    end
    check("idle_quiet", 32'(cnt), 32'd0);
    req_i = '1;
    wait_ack(waited);
    check("idle_ptr.ack", 32'(ack_o), 32'(4'b1000));
    req_i = '0;
    wait_res("idle_ptr");
    check("idle_ptr.res_ch", 32'(res_ch_o), 32'd3);

    // Reset in the middle of a ch1 word
    @(negedge clk);
    data_i[1*WORD_W +: WORD_W] = 8'hAA;
    req_i[1] = 1'b1;
    wait_ack(waited);
    check("mid_rst.ack", 32'(ack_o), 32'(4'b0010));
    req_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst.outputs",
          32'({ack_o, busy_o, bit_o, hit_o, res_valid_o, res_ch_o, res_cnt_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid_o !== 1'b0 || busy_o !== 1'b0) cnt++;
    end
    check("mid_rst.no_result", 32'(cnt), 32'd0);
    run_vector(8, '{2'd1, 8'h0A, 8'h80, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Time-shares one serial "1010" Mealy detector among NUM_CH parallel-word requesters. A round-robin arbiter grants one requester at a time, latches its word, and shifts it MSB-first through the detector, one bit per cycle. At the end of the word it reports the requester id and the number of "1010" hits. It sits between the per-channel word sources and the result consumer, in place of one detector instance per channel.

## Interface
- NUM_CH, default 4: number of requesters, ≥2.
- WORD_W, default 8: bits per word, ≥4.
- CH_W, derived $clog2(NUM_CH): width of the channel id.
- CNT_W, derived $clog2(WORD_W+1): width of the hit count.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NUM_CH  per-channel request; level, held until ack.
- data_i  in  NUM_CH*WORD_W  flattened words; channel k uses bits [k*WORD_W +: WORD_W]; must be stable while req_i[k] is high.
- ack_o  out  NUM_CH  one-hot, one-cycle pulse: word k accepted.
- busy_o  out  1  high while a word is being shifted.
- bit_o  out  1  bit currently presented to the detector.
- hit_o  out  1  Mealy hit: final 0 of "1010" is present this cycle.
- res_valid_o  out  1  one-cycle pulse: result is ready.
- res_ch_o  out  CH_W  channel id of the result.
- res_cnt_o  out  CNT_W  hit count of the result.

## Operation
- Reset values: state IDLE, detector state A, RR pointer 0, shift register 0, counter 0, all outputs 0. res_ch_o and res_cnt_o hold their values until the next res_valid_o.
- Control FSM:
  - IDLE → SHIFT on any req_i sampled high.
  - SHIFT → IDLE after WORD_W bits have been consumed.
- Arbitration: search req_i upward from the pointer, wrapping modulo NUM_CH. On a grant to channel k, pointer ← (k+1) mod NUM_CH. With no requests, the pointer is unchanged.
- On grant, in a single edge:
  - shift register ← data_i[k]
  - channel register ← k
  - counter ← 0
  - detector ← A
  - bit index ← WORD_W-1
  - ack_o[k] ← 1 for one cycle
- Requests are ignored in SHIFT. A request whose req_i is still high after its ack is treated as a new word.
- Detector transitions on bit_o:
  - A: 0→A, 1→B
  - B: 0→C, 1→B
  - C: 0→A, 1→D
  - D: 0→A (or C, see Configuration), 1→B
- hit_o = (state==SHIFT) && (det==D) && !bit_o. It is derived only from registers.
- Counter increments on each edge where hit_o=1. It is sized so it cannot overflow.
- The detector restarts at A for every word. There is no matching across word boundaries.

## Timing
- Edge E0 samples req_i and makes the grant.
- Cycle 1: ack_o and busy_o go high; bit_o = word[WORD_W-1].
- Cycle j (1..WORD_W): bit_o = word[WORD_W-j]. Edge Ej consumes that bit.
- Edge E(WORD_W): state → IDLE; busy_o drops; res_valid_o is high in cycle WORD_W+1, with res_cnt_o including any hit on the last bit.
- The next grant is sampled at edge E(WORD_W+1), so ack_o can go high in cycle WORD_W+2. Throughput is one word per WORD_W+1 cycles.
- Simultaneous requests: exactly one ack per grant, in RR order.
- Reset mid-word:
  - outputs clear immediately;
  - the latched word is discarded with no res_valid_o;
  - the requester must re-request.

## Configuration
- SEQ_SCHED_OVERLAP_EN defined: D with 0 → C, giving overlapping detection (trailing "10" is reused).
- SEQ_SCHED_OVERLAP_EN undefined: D with 0 → A, giving non-overlapping detection.
- Word 8'hAA produces a count of 3 with the macro and 2 without it.

## Structure
- Package seq_sched_pkg holds:
  - control state enum {IDLE, SHIFT};
  - detector state enum {DET_A, DET_B, DET_C, DET_D}, 2 bits;
  - CH_W and CNT_W derivation functions.
- Sub-module rr_arbiter:
  - inputs: req, pointer;
  - outputs: one-hot grant, encoded index, any-request flag;
  - purely combinational. The pointer register lives in the parent.

## Test plan
- Reset: rst=0 mid-shift of ch1 → all outputs 0 at once; after release no res_valid_o; ch1 re-request gets ack and a fresh result.
- Single request: ch2, data 8'b0101_1010 → ack_o=4'b0100 in cycle 1; hit_o in cycle 8; res_valid_o in cycle 9 with res_ch_o=2, res_cnt_o=1.
- Overlap: ch0, data 8'hAA → res_cnt_o=3 with SEQ_SCHED_OVERLAP_EN, 2 without.
- Round robin: all four req_i held high continuously → acks in order ch0, ch1, ch2, ch3, ch0, spaced 9 cycles apart.
- Boundary: data 8'h0A then 8'h0A back-to-back from ch1 → each word gives count 1. Data 8'hA0 gives count 1; data 8'h05 gives 0, confirming no cross-word carry from the preceding word.
- Idle / no hits: no requests for 20 cycles → busy_o=0, pointer unchanged. Data 8'hFF → res_cnt_o=0 and hit_o never asserts.
